key_input_conditioner: RTL and testbench

Conditions raw push-button inputs into clean per-key press events for the game content logic. Provides per key:
- a two-flop synchronizer;
- a counter-based debouncer;
- a one-cycle press pulse with optional hold-to-repeat.

The `key` output connects directly to the `key[3:0]` input of the game content / dialog stage. All outputs are registered.

---
 rtl/key_input_conditioner.sv | 176 +++++++++++++++++
 tb/tb_key_input_conditioner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// key_input_conditioner
//
// Turns raw, bouncing push-button levels into clean per-key events for the
// game content / dialog logic. Each key has its own path, and no key affects
// another:
//   btn_raw -> two-flop synchronizer -> counter debouncer -> event FSM
//
// A new debounced level is accepted only after DEBOUNCE_CYCLES consecutive
// synchronized samples that differ from the current level. A rising debounced
// level produces a one-cycle press pulse. While the key stays down, the FSM
// auto-repeats: the first repeat comes REPEAT_DELAY cycles after the press
// pulse, and later repeats come every REPEAT_PERIOD cycles. REPEAT_DELAY = 0
// turns auto-repeat off. Releasing a key never produces a pulse.
//
// Ports:
//   clk        in   system clock (pixel clock domain)
//   rst        in   asynchronous, active-low reset
//   btn_raw    in   [N_KEYS]   raw button levels, 1 = pressed, asynchronous
//   key        out  [N_KEYS]   one-cycle press / repeat pulses (registered)
//   key_held   out  [N_KEYS]   debounced level per key (registered)
//   key_any    out  1          OR of the pulses, coincident with key
//   state_dbg  out  [2*N_KEYS] event FSM state per key, key k in bits
//                              [2k+1:2k]: 0 = RELEASED, 1 = HOLD_DELAY,
//                              2 = HOLD_REPEAT
module key_input_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int REPEAT_DELAY    = 32500000,
  parameter int REPEAT_PERIOD   = 6500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_KEYS-1:0]     btn_raw,
  output logic [N_KEYS-1:0]     key,
  output logic [N_KEYS-1:0]     key_held,
  output logic                  key_any,
  output logic [2*N_KEYS-1:0]   state_dbg
);

  localparam int DCNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HCNT_W = (HMAX < 1) ? 1 : $clog2(HMAX + 1);

  localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE    = DCNT_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_ONE    = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_DELAY  = HCNT_W'(REPEAT_DELAY);
  localparam logic [HCNT_W-1:0] HCNT_PERIOD = HCNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } state_e;

  logic [N_KEYS-1:0] s1_q, s1_d;
  logic [N_KEYS-1:0] s2_q, s2_d;
  logic [N_KEYS-1:0] db_q, db_d;
  logic [N_KEYS-1:0] key_q, key_d;
  logic              key_any_q, key_any_d;

  logic [DCNT_W-1:0] dcnt_q [N_KEYS];
  logic [DCNT_W-1:0] dcnt_d [N_KEYS];
  logic [HCNT_W-1:0] hcnt_q [N_KEYS];
  logic [HCNT_W-1:0] hcnt_d [N_KEYS];
  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];

  always_comb begin
    s1_d = btn_raw;
    s2_d = s1_q;
    db_d = db_q;
    key_d = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      dcnt_d[k]  = dcnt_q[k];
      hcnt_d[k]  = hcnt_q[k];
      state_d[k] = state_q[k];
    end

    for (int k = 0; k < N_KEYS; k++) begin
      // Debouncer: any sample that agrees with the current level restarts
      // the count, so only an unbroken run of disagreeing samples wins.
      if (s2_q[k] == db_q[k]) begin
        dcnt_d[k] = '0;
      end else if (dcnt_q[k] == DCNT_LAST) begin
        db_d[k]   = s2_q[k];
        dcnt_d[k] = '0;
      end else begin
        dcnt_d[k] = dcnt_q[k] + DCNT_ONE;
      end

      // The event FSM looks at the next debounced level. The press pulse
      // therefore registers on the same edge as key_held, and a release
      // takes priority over a repeat pulse that lands on the same edge.
      case (state_q[k])
        RELEASED: begin
          if (db_d[k] && !db_q[k]) begin
            key_d[k]   = 1'b1;
            hcnt_d[k]  = HCNT_ONE;
            state_d[k] = HOLD_DELAY;
          end
        end
        HOLD_DELAY: begin
          if (!db_d[k]) begin
            hcnt_d[k]  = '0;
            state_d[k] = RELEASED;
          end else if (REPEAT_DELAY == 0) begin
            // Auto-repeat is off: park here without counting.
            hcnt_d[k] = hcnt_q[k];
          end else if (hcnt_q[k] == HCNT_DELAY) begin
            key_d[k]   = 1'b1;
            hcnt_d[k]  = HCNT_ONE;
            state_d[k] = HOLD_REPEAT;
          end else begin
            hcnt_d[k] = hcnt_q[k] + HCNT_ONE;
          end
        end
        HOLD_REPEAT: begin
          if (!db_d[k]) begin
            hcnt_d[k]  = '0;
            state_d[k] = RELEASED;
          end else if (hcnt_q[k] == HCNT_PERIOD) begin
            key_d[k]  = 1'b1;
            hcnt_d[k] = HCNT_ONE;
          end else begin
            hcnt_d[k] = hcnt_q[k] + HCNT_ONE;
          end
        end
        default: begin
          hcnt_d[k]  = '0;
          state_d[k] = RELEASED;
        end
      endcase
    end

    key_any_d = |key_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      key_q     <= '0;
      key_any_q <= 1'b0;
      for (int k = 0; k < N_KEYS; k++) begin
        dcnt_q[k]  <= '0;
        hcnt_q[k]  <= '0;
        state_q[k] <= RELEASED;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      key_q     <= key_d;
      key_any_q <= key_any_d;
      for (int k = 0; k < N_KEYS; k++) begin
        dcnt_q[k]  <= dcnt_d[k];
        hcnt_q[k]  <= hcnt_d[k];
        state_q[k] <= state_d[k];
      end
    end
  end

  always_comb begin
    state_dbg = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      state_dbg[2*k +: 2] = state_q[k];
    end
  end

  assign key      = key_q;
  assign key_held = db_q;
  assign key_any  = key_any_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
module tb_key_input_conditioner;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NK-1:0] btn_a, btn_b;
  logic [NK-1:0] key_a, held_a, key_b, held_b;
  logic          any_a, any_b;
  logic [2*NK-1:0] dbg_a, dbg_b;

  key_input_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_a), .key(key_a), .key_held(held_a),
    .key_any(any_a), .state_dbg(dbg_a)
  );

  key_input_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)
  ) dut_nr (
    .clk(clk), .rst(rst), .btn_raw(btn_b), .key(key_b), .key_held(held_b),
    .key_any(any_b), .state_dbg(dbg_b)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounced level flips when the last DB synchronized samples all disagree
  // with it; pulses come from arithmetic on the cycle of the press.
  logic [NK-1:0] m_dl0 [2];
  logic [NK-1:0] m_dl1 [2];
  bit            m_db    [2][NK];
  int            m_press [2][NK];
  bit            m_win   [2][NK][$];

  task automatic model_reset(int m);
    m_dl0[m] = '0;
    m_dl1[m] = '0;
    for (int k = 0; k < NK; k++) begin
      m_db[m][k]    = 1'b0;
      m_press[m][k] = 0;
      m_win[m][k].delete();
    end
  endtask

  task automatic model_edge(int m, logic [NK-1:0] btn, int rd, int rp,
                            output logic [NK-1:0] ek, output logic [NK-1:0] eh,
                            output logic ea);
    logic [NK-1:0] smp;
    bit prev, differ;
    int e;
    smp = m_dl1[m];
    m_dl1[m] = m_dl0[m];
    m_dl0[m] = btn;
    ek = '0;
    eh = '0;
    for (int k = 0; k < NK; k++) begin
      m_win[m][k].push_back(smp[k]);
      if (m_win[m][k].size() > DB) void'(m_win[m][k].pop_front());
      prev = m_db[m][k];
      differ = (m_win[m][k].size() == DB);
      for (int i = 0; i < m_win[m][k].size(); i++)
        if (m_win[m][k][i] == prev) differ = 1'b0;
      if (differ) m_db[m][k] = !prev;
      if (m_db[m][k] && !prev) begin
        m_press[m][k] = cyc;
        ek[k] = 1'b1;
      end else if (m_db[m][k] && prev && rd > 0) begin
        e = cyc - m_press[m][k];
        if (e >= rd && (e - rd) % rp == 0) ek[k] = 1'b1;
      end
      eh[k] = m_db[m][k];
    end
    ea = |ek;
  endtask

  // ---------------- driver: one clock edge + model check ----------------
  task automatic step();
    logic [NK-1:0] eka, eha, ekb, ehb;
    logic eaa, eab;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      model_reset(0);
      model_reset(1);
      eka = '0; eha = '0; eaa = 1'b0;
      ekb = '0; ehb = '0; eab = 1'b0;
    end else begin
      model_edge(0, btn_a, RD, RP, eka, eha, eaa);
      model_edge(1, btn_b, 0, RP, ekb, ehb, eab);
    end
    check("model key", 32'(key_a), 32'(eka));
    check("model key_held", 32'(held_a), 32'(eha));
    check("model key_any", 32'(any_a), 32'(eaa));
    check("model norep key", 32'(key_b), 32'(ekb));
    check("model norep key_held", 32'(held_b), 32'(ehb));
    check("model norep key_any", 32'(any_b), 32'(eab));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NK-1:0] btn;
    logic [NK-1:0] key;
    logic [NK-1:0] held;
    logic          any_v;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vecs(int count, logic [NK-1:0] btn, logic [NK-1:0] k,
                          logic [NK-1:0] h, logic a);
    vec_t v;
    v.btn = btn; v.key = k; v.held = h; v.any_v = a;
    for (int i = 0; i < count; i++) vecs.push_back(v);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int rate;

  task automatic compare_pulses(string name);
    check({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({name, " index"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    // Clean press of key 0: press seen 6 edges after the change.
    add_vecs(5, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add_vecs(1, 4'b0001, 4'b0001, 4'b0001, 1'b1);
    add_vecs(4, 4'b0001, 4'b0000, 4'b0001, 1'b0);
    add_vecs(5, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    add_vecs(5, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    // Simultaneous keys 3 and 0.
    add_vecs(5, 4'b1001, 4'b0000, 4'b0000, 1'b0);
    add_vecs(1, 4'b1001, 4'b1001, 4'b1001, 1'b1);
    add_vecs(4, 4'b1001, 4'b0000, 4'b1001, 1'b0);
    add_vecs(5, 4'b0000, 4'b0000, 4'b1001, 1'b0);
    add_vecs(5, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    rst = 1'b0;
    btn_a = '0;
    btn_b = '0;
    step();
    step();
    check("reset state_dbg", 32'(dbg_a), 32'd0);
    rst = 1'b1;

    // ---- table-driven section ----
    for (int j = 0; j < vecs.size(); j++) begin
      btn_a = vecs[j].btn;
      step();
      check("tbl key", 32'(key_a), 32'(vecs[j].key));
      check("tbl key_held", 32'(held_a), 32'(vecs[j].held));
      check("tbl key_any", 32'(any_a), 32'(vecs[j].any_v));
    end

    // ---- bounce on key 1 ----
    begin
      logic [7:0] pat;
      pat = 8'b0011_0011; // bit i drives step i: 1,1,0,0,1,1,0,0
      for (int i = 0; i < 35; i++) begin
        if (i < 8) btn_a = {2'b00, pat[i], 1'b0};
        else if (i < 20) btn_a = 4'b0010;
        else btn_a = 4'b0000;
        step();
        if (key_a[1]) got_q.push_back(32'(i));
      end
      exp_q.push_back(32'd13);
      compare_pulses("bounce pulse");
    end

    // ---- auto-repeat on key 2; release lands on the P+60 repeat slot ----
    for (int i = 0; i < 90; i++) begin
      btn_a = (i < 60) ? 4'b0100 : 4'b0000;
      step();
      if (key_a[2]) got_q.push_back(32'(i));
    end
    exp_q.push_back(32'd5);
    exp_q.push_back(32'd25);
    exp_q.push_back(32'd33);
    exp_q.push_back(32'd41);
    exp_q.push_back(32'd49);
    exp_q.push_back(32'd57);
    compare_pulses("repeat pulse");

    // ---- reset while key 3 is in HOLD_REPEAT ----
    btn_a = 4'b1000;
    for (int i = 0; i < 30; i++) step();
    check("pre-reset key_held", 32'(held_a), 32'h8);
    check("pre-reset state", 32'(dbg_a[7:6]), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("async reset key", 32'(key_a), 32'd0);
    check("async reset key_held", 32'(held_a), 32'd0);
    check("async reset key_any", 32'(any_a), 32'd0);
    check("async reset state", 32'(dbg_a), 32'd0);
    step();
    step();
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (key_a[3]) got_q.push_back(32'(i));
    end
    exp_q.push_back(32'd6);
    compare_pulses("post-reset pulse");
    btn_a = '0;
    for (int i = 0; i < 10; i++) step();

    // ---- repeat disabled: long hold, one pulse ----
    btn_b = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      step();
      if (key_b[0]) got_q.push_back(32'(i));
    end
    exp_q.push_back(32'd5);
    compare_pulses("norep pulse");
    btn_b = '0;
    for (int i = 0; i < 10; i++) step();

    // ---- randomized bouncing on all keys, both instances ----
    rate = 40;
    for (int c = 0; c < 1500; c++) begin
      if (c % 200 == 0) rate = (rate == 3) ? 40 : 3;
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, rate) == 0) btn_a[k] = ~btn_a[k];
        if ($urandom_range(0, rate) == 0) btn_b[k] = ~btn_b[k];
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
